// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
// Shared definitions for both ends of the bit-serial link (piso_serializer on
// the transmit side, sipo_reg on the receive side).
//   - default word width and clocks-per-bit
//   - FSM state codes for the transmitter (IDLE / SHIFT)
//   - helper to size the per-bit tick counter
// -----------------------------------------------------------------------------
package serial_link_pkg;

    localparam int SERIAL_LINK_WIDTH        = 8;
    localparam int SERIAL_LINK_CLKS_PER_BIT = 1;

    // Transmitter FSM state codes, kept as plain constants so the encoding
    // is visible on the debug port without any enum casting.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Width of a modulo-clks counter; never narrower than one bit so that
    // clks == 1 still yields a legal (constant-zero) register.
    function automatic int tick_cnt_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// -----------------------------------------------------------------------------
// bit_tick_gen
// Modulo-CLKS_PER_BIT counter that marks the last clock of each serial bit.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  synchronous active-low reset (count -> 0)
//   clear   in  synchronous restart of the count at 0 (beats enable)
//   enable  in  advance the count this cycle
//   tick    out high while the count sits on its final value
// -----------------------------------------------------------------------------
module bit_tick_gen
    import serial_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = SERIAL_LINK_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = tick_cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With CLKS_PER_BIT == 1 the count is stuck at 0 == LAST, so tick is
    // permanently high; the caller qualifies it with its own state.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word on a
// valid/ready handshake and sends it MSB first, one bit per CLKS_PER_BIT
// clocks, each bit marked by a one-cycle bit_valid strobe.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready
// && !abort. in_ready depends only on registered state, never on in_valid,
// and data_in is sampled only on that edge.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   in_valid    in   data_in holds a word to send
//   data_in     in   parallel word [WIDTH-1:0]
//   in_ready    out  a word is accepted this cycle if in_valid is high
//   abort       in   synchronous flush of the frame in progress
//   bit_out     out  current serial bit (MSB of the shift register)
//   bit_valid   out  one-cycle strobe: sample bit_out now
//   busy        out  a frame is in progress
//   frame_done  out  one-cycle pulse on the strobe of the last bit
//   dbg_state   out  FSM state (ST_IDLE / ST_SHIFT)
// -----------------------------------------------------------------------------
module piso_serializer
    import serial_link_pkg::*;
#(
    parameter int WIDTH        = SERIAL_LINK_WIDTH,
    parameter int CLKS_PER_BIT = SERIAL_LINK_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             in_ready,
    input  logic             abort,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             frame_done,
    output logic             dbg_state
);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("piso_serializer: WIDTH must be >= 2");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_clks
            $error("piso_serializer: CLKS_PER_BIT must be >= 1");
        end
    endgenerate

    localparam int            BW        = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BITS_FULL = BW'(WIDTH);
    localparam logic [BW-1:0] BITS_ONE  = BW'(1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bits_left_q, bits_left_d;

    logic tick;
    logic strobe;
    logic last_bit;
    logic accept;

    // Decoded from registered state only.
    assign strobe   = (state_q == ST_SHIFT) && tick;
    assign last_bit = strobe && (bits_left_q == BITS_ONE);
    assign accept   = in_valid && in_ready && !abort;

    assign bit_out    = sreg_q[WIDTH-1];
    assign busy       = (state_q == ST_SHIFT);
    assign bit_valid  = strobe;
    assign frame_done = last_bit;
    // Ready also on the last strobe so a new word can follow with no gap.
    assign in_ready   = (state_q == ST_IDLE) || last_bit;
    assign dbg_state  = state_q;

    // Restarting the bit timer on a load aligns the first strobe to
    // CLKS_PER_BIT clocks after the handshake edge.
    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (abort || accept),
        .enable (state_q == ST_SHIFT),
        .tick   (tick)
    );

    // Priority: abort > load > shift. A load on the last-bit edge overrides
    // the return to IDLE.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bits_left_d = bits_left_q;
        if (abort) begin
            state_d     = ST_IDLE;
            sreg_d      = '0;
            bits_left_d = '0;
        end else if (accept) begin
            state_d     = ST_SHIFT;
            sreg_d      = data_in;
            bits_left_d = BITS_FULL;
        end else if (strobe) begin
            sreg_d      = {sreg_q[WIDTH-2:0], 1'b0};
            bits_left_d = bits_left_q - BITS_ONE;
            if (last_bit) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sreg_q      <= '0;
            bits_left_q <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            bits_left_q <= bits_left_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
// Two transmitters side by side: instance 0 with one clock per bit, instance 1
// with four. A frame-level reference model (active flag, handshake edge,
// loaded word) predicts every output each cycle; accepted words are queued
// and popped by a receiver model on frame_done.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W    = 8;
    localparam int NDUT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0] rst_n, in_valid, abort;
    logic [NDUT-1:0] in_ready, bit_out, bit_valid, busy, frame_done, dbg_state;
    logic [W-1:0]    data_in [NDUT];

    piso_serializer #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .data_in(data_in[0]),
        .in_ready(in_ready[0]), .abort(abort[0]), .bit_out(bit_out[0]),
        .bit_valid(bit_valid[0]), .busy(busy[0]), .frame_done(frame_done[0]),
        .dbg_state(dbg_state[0])
    );

    piso_serializer #(.WIDTH(W), .CLKS_PER_BIT(4)) u_dut_c4 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .data_in(data_in[1]),
        .in_ready(in_ready[1]), .abort(abort[1]), .bit_out(bit_out[1]),
        .bit_valid(bit_valid[1]), .busy(busy[1]), .frame_done(frame_done[1]),
        .dbg_state(dbg_state[1])
    );

    function automatic int cpb_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    task automatic check1(input string name, input int d, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %b expected %b", name, d, $time, act, req);
        end
    endtask

    task automatic check_word(input string name, input int d, input logic [W-1:0] act,
                              input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, req);
        end
    endtask

    task automatic q_push(input int d, input logic [W-1:0] w);
        if (d == 0) exp_q0.push_back(w);
        else        exp_q1.push_back(w);
    endtask

    task automatic q_clear(input int d);
        if (d == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic q_pop(input int d, output logic [W-1:0] w);
        if (d == 0) w = exp_q0.pop_front();
        else        w = exp_q1.pop_front();
    endtask

    // ---------------- reference model ----------------
    // A frame is "active" from its handshake edge t0 until edge t0 + W*CPB.
    // Bit k is on the line during cycles t0+k*CPB .. t0+(k+1)*CPB-1 and is
    // strobed in the last of those cycles.
    typedef struct packed {
        logic strobe;
        logic bit_o;
        logic busy;
        logic fd;
        logic ready;
    } mexp_t;

    bit           m_active [NDUT];
    int           m_t0     [NDUT];
    logic [W-1:0] m_word   [NDUT];
    int           acc_cnt  [NDUT];
    int           cyc = 0;

    function automatic mexp_t model_out(input int d);
        mexp_t e;
        int n, k, c;
        e = '0;
        e.ready = 1'b1;
        if (m_active[d]) begin
            c = cpb_of(d);
            n = cyc - m_t0[d];
            k = n / c;
            if (k > W - 1) k = W - 1;
            e.strobe = ((n % c) == c - 1);
            e.bit_o  = m_word[d][W-1-k];
            e.busy   = 1'b1;
            e.fd     = e.strobe && (k == W - 1);
            e.ready  = e.fd;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        mexp_t e;
        for (int d = 0; d < NDUT; d++) begin
            e = model_out(d);
            if (!rst_n[d] || abort[d]) begin
                m_active[d] = 1'b0;
                q_clear(d);
            end else if (in_valid[d] && e.ready) begin
                m_active[d] = 1'b1;
                m_t0[d]     = cyc + 1;
                m_word[d]   = data_in[d];
                q_push(d, data_in[d]);
                acc_cnt[d]  = acc_cnt[d] + 1;
            end else if (e.fd) begin
                m_active[d] = 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- monitor ----------------
    bit           chk_en [NDUT];
    logic [W-1:0] rx     [NDUT];

    always @(negedge clk) begin
        mexp_t e;
        logic [W-1:0] w;
        for (int d = 0; d < NDUT; d++) begin
            if (chk_en[d]) begin
                e = model_out(d);
                check1("bit_valid",  d, bit_valid[d],  e.strobe);
                check1("bit_out",    d, bit_out[d],    e.bit_o);
                check1("busy",       d, busy[d],       e.busy);
                check1("frame_done", d, frame_done[d], e.fd);
                check1("in_ready",   d, in_ready[d],   e.ready);
                if (bit_valid[d] === 1'b1) rx[d] = {rx[d][W-2:0], bit_out[d]};
                if (frame_done[d] === 1'b1) begin
                    if (q_size(d) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_underflow dut%0d t=%0t: got frame_done expected none", d, $time);
                    end else begin
                        q_pop(d, w);
                        check_word("rx_word", d, rx[d], w);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int d, input logic [W-1:0] w, input bit hold);
        int a0;
        a0 = acc_cnt[d];
        in_valid[d] = 1'b1;
        data_in[d]  = w;
        for (int i = 0; i < 200 && acc_cnt[d] == a0; i++) @(negedge clk);
        checks++;
        if (acc_cnt[d] == a0) begin
            errors++;
            $display("FAIL accept_timeout dut%0d: got no handshake expected one", d);
        end
        if (!hold) in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int i;
        for (i = 0; i < 500 && (busy[d] !== 1'b0 || m_active[d]); i++) @(negedge clk);
        checks++;
        if (i == 500) begin
            errors++;
            $display("FAIL idle_timeout dut%0d: got busy=%b expected 0", d, busy[d]);
        end
    endtask

    task automatic wait_strobes(input int d, input int n);
        int cnt;
        int i;
        cnt = 0;
        for (i = 0; i < 500; i++) begin
            if (bit_valid[d] === 1'b1) cnt++;
            if (cnt == n) break;
            @(negedge clk);
        end
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL strobe_timeout dut%0d: got %0d strobes expected %0d", d, cnt, n);
        end
    endtask

    task automatic check_reset_vals(input int d, input string tag);
        check1({tag, "_bit_out"},    d, bit_out[d],    1'b0);
        check1({tag, "_bit_valid"},  d, bit_valid[d],  1'b0);
        check1({tag, "_busy"},       d, busy[d],       1'b0);
        check1({tag, "_frame_done"}, d, frame_done[d], 1'b0);
        check1({tag, "_in_ready"},   d, in_ready[d],   1'b1);
    endtask

    task automatic run_suite(input int d);
        int c;
        logic [W-1:0] w;
        c = cpb_of(d);

        // basic loopback
        send(d, 8'hA5, 1'b0);
        wait_idle(d);

        // back-to-back with in_valid held
        send(d, 8'h3C, 1'b1);
        send(d, 8'hC3, 1'b0);
        wait_idle(d);

        // pacing
        send(d, 8'h81, 1'b0);
        wait_idle(d);

        // in_valid while busy is ignored
        send(d, 8'h0F, 1'b0);
        repeat (3 * c) @(negedge clk);
        in_valid[d] = 1'b1;
        data_in[d]  = 8'hFF;
        check1("ignored_ready", d, in_ready[d], 1'b0);
        @(negedge clk);
        in_valid[d] = 1'b0;
        wait_idle(d);

        // abort after the 3rd strobe
        send(d, 8'h55, 1'b0);
        wait_strobes(d, 3);
        @(negedge clk);
        abort[d] = 1'b1;
        @(negedge clk);
        abort[d] = 1'b0;
        check_reset_vals(d, "abort");
        send(d, 8'hAA, 1'b0);
        wait_idle(d);

        // reset in the middle of a frame
        send(d, 8'h96, 1'b0);
        wait_strobes(d, 5);
        @(negedge clk);
        rst_n[d] = 1'b0;
        @(negedge clk);
        rst_n[d] = 1'b1;
        check_reset_vals(d, "midrst");
        repeat (3 * c) @(negedge clk);
        send(d, 8'h6B, 1'b0);
        wait_idle(d);

        // randomized traffic with occasional aborts
        for (int i = 0; i < 24; i++) begin
            w = W'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                send(d, w, 1'b0);
                repeat ($urandom_range(0, W * c - 1)) @(negedge clk);
                abort[d]    = 1'b1;
                in_valid[d] = 1'($urandom_range(0, 1));
                data_in[d]  = W'($urandom);
                @(negedge clk);
                abort[d]    = 1'b0;
                in_valid[d] = 1'b0;
            end else begin
                send(d, w, 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                in_valid[d] = 1'b0;
            end
        end
        wait_idle(d);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n    = '0;
        in_valid = '0;
        abort    = '0;
        for (int d = 0; d < NDUT; d++) begin
            data_in[d]  = '0;
            rx[d]       = '0;
            chk_en[d]   = 1'b0;
            m_active[d] = 1'b0;
            m_t0[d]     = 0;
            m_word[d]   = '0;
            acc_cnt[d]  = 0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk_en[d] = 1'b1;
            check_reset_vals(d, "reset");
        end
        rst_n = '1;
        @(negedge clk);

        for (int d = 0; d < NDUT; d++) run_suite(d);

        repeat (4) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (q_size(d) != 0) begin
                errors++;
                $display("FAIL leftover_words dut%0d: got %0d expected 0", d, q_size(d));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter for the serial link whose receive end is the `sipo_reg` shift register. It accepts a WIDTH-bit word through a valid/ready handshake and emits it MSB-first on `bit_out`, one bit per CLKS_PER_BIT clocks. Each bit is paired with a one-cycle `bit_valid` strobe, which drives the receiver's `shift_en` directly. After WIDTH strobes the receiver holds the exact word that was loaded here.

## Interface
- `WIDTH`, default 8: word length in bits; must be ≥ 2.
- `CLKS_PER_BIT`, default 1: clocks per serial bit; must be ≥ 1.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  `data_in` holds a word to send.
- `data_in`  in  WIDTH  parallel word; sampled only on the handshake edge.
- `in_ready`  out  1  the block accepts a word this cycle.
- `abort`  in  1  synchronous flush of the frame in progress.
- `bit_out`  out  1  current serial bit (MSB of the shift register).
- `bit_valid`  out  1  one-cycle strobe: `bit_out` is to be sampled now.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse on the strobe of the last bit.

## Operation
- **Internal state:** a WIDTH-bit shift register `sreg`, a bit counter `bits_left` of $clog2(WIDTH+1) bits, a tick counter of $clog2(CLKS_PER_BIT) bits (minimum 1), and a 2-state FSM with states IDLE and SHIFT.
- **Output rule:** every output is decoded from registered state only; there is no combinational path from any input to any output.
  - `bit_out` = `sreg[WIDTH-1]`.
  - `busy` = (state == SHIFT).
  - `strobe` = SHIFT && tick == CLKS_PER_BIT-1.
  - `bit_valid` = `strobe`.
  - `frame_done` = `strobe` && `bits_left` == 1.
  - `in_ready` = IDLE || `frame_done`.
- **Handshake:** a word is accepted when `in_valid && in_ready && !abort`. On that edge:
  - `sreg` <= `data_in`;
  - `bits_left` <= WIDTH;
  - tick <= 0;
  - state <= SHIFT.
- **Shifting:**
  - In SHIFT the tick counter increments each cycle and wraps to 0 after CLKS_PER_BIT-1.
  - On a `strobe` edge, `sreg` shifts left with 0 filled in at the LSB, and `bits_left` decrements.
- **End of frame:** on the `frame_done` edge the state goes to IDLE, unless a new word is accepted on the same edge. In that case the load takes priority: the new word is loaded and the state stays SHIFT, with no idle gap between frames.
- **`in_valid` with `in_ready` low:** ignored. `data_in` is not sampled and the frame in progress is unaffected.
- **`abort`:**
  - Priority: `rst_n` > `abort` > handshake > shift.
  - `abort` high forces state to IDLE, `sreg` to 0, and both counters to 0.
  - No `frame_done` is produced, and no word is accepted on that edge.
- **Reset:** `rst_n` low at a clock edge has the same effect as `abort`, including in the middle of a frame.
- **Reset values:** `bit_out`=0, `bit_valid`=0, `busy`=0, `frame_done`=0, `in_ready`=1 (once `rst_n` is high).

## Timing
- **First bit:** handshake on edge T0 → `bit_out` shows the MSB from T0+. The first `bit_valid` is high in the cycle before edge T0+CLKS_PER_BIT.
- **Bit k:** the strobe for bit k (k=0..WIDTH-1) is in the cycle ending at edge T0+(k+1)·CLKS_PER_BIT.
- **Bit stability:** `bit_out` is stable for CLKS_PER_BIT cycles and changes only on strobe edges.
- **Throughput:** with `in_valid` held high, one word per WIDTH·CLKS_PER_BIT cycles, with no gap cycle.
- **CLKS_PER_BIT=1:** `bit_valid` is high every SHIFT cycle.
- **Receiver link:** the receiver registers `bit_out` on each `bit_valid` edge. After the `frame_done` edge its `data_out` equals the loaded word.

## Structure
- **Package `serial_link_pkg`:** the FSM state enum (IDLE, SHIFT) and the `serial_link_*` parameter defaults (word width, clocks per bit), shared with the receive side.
- **Sub-module `bit_tick_gen`:** CLKS_PER_BIT modulo counter with synchronous `clear` and `enable` inputs and a `tick` output. Reusable later to pace the receiver.
- **Parameter checks:** elaboration fails if WIDTH < 2 or CLKS_PER_BIT < 1.

## Test plan
- **Basic loopback:** WIDTH=8, CLKS_PER_BIT=1. Load 0xA5 → `bit_out` at strobes = 1,0,1,0,0,1,0,1; `frame_done` coincides with the 8th strobe; a `sipo_reg` fed from `bit_out`/`bit_valid` holds 0xA5.
- **Back-to-back:** `in_valid` held high with 0x3C then 0xC3 → 16 consecutive strobe cycles, `in_ready` high only on the `frame_done` cycle, and the receiver reads 0x3C then 0xC3.
- **Pacing:** CLKS_PER_BIT=4, load 0x81 → strobes at cycles 4, 8, …, 32 after the handshake; `bit_out` constant between strobes; `busy` high for exactly 32 cycles.
- **Ignored input:** `in_valid` pulsed with 0xFF in the middle of a 0x0F frame → `in_ready` is low at that time, and the output sequence remains 0x0F.
- **Abort:** `abort` asserted after the 3rd strobe of 0x55 → the next cycle shows `busy`=0, `bit_out`=0, no `frame_done`, `in_ready`=1; a following load of 0xAA transmits correctly.
- **Reset mid-frame:** `rst_n` low for 1 cycle after the 5th strobe → all outputs take their reset values; no further strobes until a new handshake.
